multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the 32-bit MIPS datapath. Replaces single-cycle decode with a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back. A single shared instruction/data memory port sits behind a request/ready handshake. Drives every datapath mux, write enable and ALU selection, and decodes the same opcode set as the existing control unit.

## Interface
Parameters:
- `RESET_STATE_IDLE`, 1: when 1, leave reset into S_IDLE for one cycle before S_FETCH. When 0, go straight to S_FETCH.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26], valid once IR is written.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the pending access this cycle.
- `mem_read`, `mem_write`  out  1  memory request; held until `mem_ready`.
- `iord`  out  1  memory address source: 0 = PC, 1 = ALUOut.
- `ir_write`, `pc_write`, `reg_write`  out  1  write enables.
- `alu_src_a`  out  1  0 = PC, 1 = rs.
- `alu_src_b`  out  2  00 = rt, 01 = const 4, 10 = imm, 11 = imm<<2.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct field.
- `pc_source`  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = rs.
- `reg_dst`  out  2  00 = rt, 01 = rd, 10 = $31.
- `mem_to_reg`  out  2  00 = ALUOut, 01 = MDR, 10 = PC.
- `load`  out  2  00 = word, 01 = half, 10 = byte.
- `extended`, `lui_control`  out  1  sign-extend the load; write imm<<16.
- `illegal`  out  1  one-cycle pulse on an unknown opcode.

## Operation
- Opcodes: lb 100000, lbu 100100, lh 100001, lhu 100101, lw 100011, sb 101000, sh 101001, sw 101011, lui 001111, addi 001000, R-type 000000, j 000010, jal 000011, beq 000100.
- jr is R-type with funct 001000.
- S_IDLE: all outputs 0. Next state is S_FETCH.
- S_FETCH: `mem_read`=1, `iord`=0, `alu_src_b`=01, `alu_op`=00.
  - Stay in S_FETCH while `mem_ready`=0.
  - On `mem_ready`=1, in the same cycle: `ir_write`=1, `pc_write`=1, `pc_source`=00. Next state is S_DECODE.
- S_DECODE: `alu_src_b`=11 (computes branch target into ALUOut). Next state by opcode:
  - load, store, addi or lui → S_ADDR.
  - R-type: jr → S_JR; otherwise → S_RTYPE.
  - beq → S_BEQ.
  - j → S_J.
  - jal → S_JAL.
  - any other opcode → `illegal`=1, next state S_FETCH.
- S_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state:
  - load → S_MEMRD.
  - store → S_MEMWR.
  - addi or lui → S_IWB.
- S_MEMRD: `mem_read`=1, `iord`=1, `load` and `extended` decoded from opcode. Wait on `mem_ready`, then go to S_LWB.
- S_LWB: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=01, `load` and `extended` held. Next state S_FETCH.
- S_MEMWR: `mem_write`=1, `iord`=1, `load` = size. Wait on `mem_ready`, then go to S_FETCH.
- S_IWB: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=00, `lui_control` = (opcode==lui). Next state S_FETCH.
- S_RTYPE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next state S_RWB.
- S_RWB: `reg_write`=1, `reg_dst`=01. Next state S_FETCH.
- S_BEQ: `alu_src_a`=1, `alu_op`=01, `pc_source`=01, `pc_write`=`zero`. Next state S_FETCH.
- S_J: `pc_write`=1, `pc_source`=10. Next state S_FETCH.
- S_JAL: as S_J, plus `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10 (PC already holds PC+4). Next state S_FETCH.
- S_JR: `pc_write`=1, `pc_source`=11. Next state S_FETCH.
- Every output not listed for a state is 0 in that state.

## Timing
- Reset value of every output is 0. State is S_IDLE (or S_FETCH when `RESET_STATE_IDLE`=0, which makes `mem_read` go to 1 immediately).
- Outputs are a Moore decode of the state register. The only exceptions are `ir_write`, `pc_write` and `illegal`, which also depend on `mem_ready`, `zero` and the decoded opcode.
- Cycles per instruction with zero-wait memory (`mem_ready` always 1):
  - lw family: 5.
  - store, R-type, addi, lui: 4.
  - beq, j, jal, jr: 3.
  - Each wait cycle adds 1.
- Handshake rules:
  - A request, once raised, stays high with stable `iord` until the edge that samples `mem_ready`=1.
  - `mem_ready` is ignored when no request is active.
  - `mem_read` and `mem_write` are never both 1.
- Reset mid-access drops the request asynchronously. No write enable fires on that cycle.

## Configuration
- `MC_PERF_CNT_EN` defined adds two outputs:
  - `inst_count[31:0]`: increments on every S_FETCH exit.
  - `stall_count[31:0]`: increments on every request cycle with `mem_ready`=0.
  - Both counters reset to 0 and wrap modulo 2^32.
- Not defined: the outputs and counters are absent, and the rest of the behaviour is identical.

## Test plan
- Reset with `rst_n`=0 mid-S_MEMRD, wait-stalled → all outputs 0 at once. After release: one S_IDLE cycle, then S_FETCH with `mem_read`=1.
- R-type add, `mem_ready`=1 → 4 cycles; `reg_write`=1 with `reg_dst`=01 in cycle 4.
- lh with 2 wait cycles on the data access → 7 cycles; S_LWB shows `load`=01, `extended`=1, `mem_to_reg`=01.
- beq: `zero`=1 → `pc_write`=1 with `pc_source`=01; `zero`=0 → `pc_write`=0. Both take 3 cycles.
- jal → S_JAL asserts `reg_dst`=10, `mem_to_reg`=10, `pc_source`=10. jr (funct 001000) → `pc_source`=11.
- Opcode 111111 → `illegal` pulses 1 cycle, no write enable asserts, and the next state is S_FETCH. With `MC_PERF_CNT_EN` defined, `inst_count` increments once.

Source files
------------

// File: rtl/multicycle_control.sv
// Purpose: multi-cycle MIPS sequencer (fetch/decode/execute/mem/write-back) driving all datapath controls.
// Latency: 3-5 cycles per instruction with zero-wait memory; each mem_ready=0 request cycle adds one.
// Backpressure: mem_read/mem_write and iord are held until mem_ready=1; optional MC_PERF_CNT_EN adds inst/stall counters.
module multicycle_control #(
    parameter int RESET_STATE_IDLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] load,
    output logic       extended,
    output logic       lui_control,
    output logic       illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] inst_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_ADDR   = 4'd3,
        S_MEMRD  = 4'd4,
        S_LWB    = 4'd5,
        S_MEMWR  = 4'd6,
        S_IWB    = 4'd7,
        S_RTYPE  = 4'd8,
        S_RWB    = 4'd9,
        S_BEQ    = 4'd10,
        S_J      = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    localparam state_t RST_STATE = (RESET_STATE_IDLE != 0) ? S_IDLE : S_FETCH;

    state_t state, state_nxt;

    // Opcode class decode; IR holds the opcode steady from decode to write-back.
    logic is_load, is_store, is_addi, is_lui, is_r, is_jr, is_beq, is_j, is_jal, is_known;
    logic [1:0] size_sel;
    logic       sign_sel;

    assign is_load  = (opcode == 6'b100000) || (opcode == 6'b100100) || (opcode == 6'b100001) ||
                      (opcode == 6'b100101) || (opcode == 6'b100011);
    assign is_store = (opcode == 6'b101000) || (opcode == 6'b101001) || (opcode == 6'b101011);
    assign is_addi  = (opcode == 6'b001000);
    assign is_lui   = (opcode == 6'b001111);
    assign is_r     = (opcode == 6'b000000);
    assign is_jr    = is_r && (funct == 6'b001000);
    assign is_beq   = (opcode == 6'b000100);
    assign is_j     = (opcode == 6'b000010);
    assign is_jal   = (opcode == 6'b000011);
    assign is_known = is_load | is_store | is_addi | is_lui | is_r | is_beq | is_j | is_jal;

    // Access size comes from opcode[1:0] (00 byte, 01 half, 11 word); bit 2 marks the unsigned loads.
    always_comb begin
        size_sel = 2'b00;
        unique case (opcode[1:0])
            2'b00:   size_sel = 2'b10;
            2'b01:   size_sel = 2'b01;
            default: size_sel = 2'b00;
        endcase
        sign_sel = (opcode[1:0] != 2'b11) && !opcode[2];
    end

    // State register; reset lands in idle or fetch depending on RESET_STATE_IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore output decode; outputs are forced low while reset is asserted
    // so a reset in the middle of an access drops the request and every write enable at once.
    always_comb begin
        state_nxt   = state;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        pc_source   = 2'b00;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        load        = 2'b00;
        extended    = 1'b0;
        lui_control = 1'b0;
        illegal     = 1'b0;
        if (rst_n) begin
            unique case (state)
                S_IDLE: begin
                    state_nxt = S_FETCH;
                end
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        state_nxt = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    if (is_load || is_store || is_addi || is_lui) state_nxt = S_ADDR;
                    else if (is_jr)                               state_nxt = S_JR;
                    else if (is_r)                                state_nxt = S_RTYPE;
                    else if (is_beq)                              state_nxt = S_BEQ;
                    else if (is_j)                                state_nxt = S_J;
                    else if (is_jal)                              state_nxt = S_JAL;
                    else                                          state_nxt = S_FETCH;
                    illegal = !is_known;
                end
                S_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (is_load)       state_nxt = S_MEMRD;
                    else if (is_store) state_nxt = S_MEMWR;
                    else               state_nxt = S_IWB;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    load     = size_sel;
                    extended = sign_sel;
                    if (mem_ready) state_nxt = S_LWB;
                end
                S_LWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                    load       = size_sel;
                    extended   = sign_sel;
                    state_nxt  = S_FETCH;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    load      = size_sel;
                    if (mem_ready) state_nxt = S_FETCH;
                end
                S_IWB: begin
                    reg_write   = 1'b1;
                    lui_control = is_lui;
                    state_nxt   = S_FETCH;
                end
                S_RTYPE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_nxt = S_RWB;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b01;
                    state_nxt = S_FETCH;
                end
                S_BEQ: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_source = 2'b01;
                    pc_write  = zero;
                    state_nxt = S_FETCH;
                end
                S_J: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    state_nxt = S_FETCH;
                end
                S_JAL: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                    state_nxt  = S_FETCH;
                end
                S_JR: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b11;
                    state_nxt = S_FETCH;
                end
                default: begin
                    state_nxt = S_FETCH;
                end
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    // Instruction count ticks on each fetch completion; stall count on each unanswered request cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_count  <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (state == S_FETCH && mem_ready) inst_count <= inst_count + 32'd1;
            if ((mem_read || mem_write) && !mem_ready) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       mem_read, mem_write, iord, ir_write, pc_write, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg, load;
    logic       extended, lui_control, illegal;
`ifdef MC_PERF_CNT_EN
    logic [31:0] inst_count, stall_count;
`endif

    multicycle_control #(.RESET_STATE_IDLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .load(load), .extended(extended), .lui_control(lui_control),
        .illegal(illegal)
`ifdef MC_PERF_CNT_EN
        , .inst_count(inst_count), .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_read, mem_write, iord, ir_write, pc_write, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg, load;
        logic       extended, lui_control, illegal;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         dwait;
        int         cycles;
        outs_t      fin;
        int         ill;
    } vec_t;

    typedef struct {
        int    idx;
        int    cycles;
        outs_t fin;
        int    ill;
    } exp_t;

    vec_t tbl [17];
    exp_t sb_q [$];
    int   checks = 0;
    int   failures = 0;

    function automatic outs_t snap();
        outs_t o;
        o = '{mem_read:mem_read, mem_write:mem_write, iord:iord, ir_write:ir_write,
              pc_write:pc_write, reg_write:reg_write, alu_src_a:alu_src_a, alu_src_b:alu_src_b,
              alu_op:alu_op, pc_source:pc_source, reg_dst:reg_dst, mem_to_reg:mem_to_reg,
              load:load, extended:extended, lui_control:lui_control, illegal:illegal};
        return o;
    endfunction

    task automatic check_int(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic check_outs(input string name, input outs_t act, input outs_t expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Runs one instruction from fetch entry to the next fetch entry, answering data requests
    // after dwait stall cycles. Entered and left at #1 after a rising edge with the FSM in fetch.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int dwait, output int cyc, output outs_t last,
                             output int ill_cnt, output int both_cnt, output bit tmo);
        int w;
        w = dwait;
        cyc = 0; ill_cnt = 0; both_cnt = 0; tmo = 1'b1; last = '0;
        opcode = op; funct = fn; zero = z;
        for (int n = 1; n <= 30; n++) begin
            if ((mem_read || mem_write) && iord && w > 0) begin
                mem_ready = 1'b0;
                w--;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            last = snap();
            if (illegal) ill_cnt++;
            if (mem_read && mem_write) both_cnt++;
            @(posedge clk);
            #1;
            if (mem_read && !iord) begin
                cyc = n;
                tmo = 1'b0;
                break;
            end
        end
    endtask

    outs_t fetch_wait;
    int    cyc, ill_cnt, both_cnt;
    bit    tmo;
    outs_t last;
    exp_t  e;

    initial begin
        tbl[0]  = '{6'b000000, 6'b100000, 1'b0, 0, 4, outs_t'{reg_write:1'b1, reg_dst:2'b01, default:'0}, 0};
        tbl[1]  = '{6'b000000, 6'b001000, 1'b0, 0, 3, outs_t'{pc_write:1'b1, pc_source:2'b11, default:'0}, 0};
        tbl[2]  = '{6'b100011, 6'b000000, 1'b0, 0, 5, outs_t'{reg_write:1'b1, mem_to_reg:2'b01, default:'0}, 0};
        tbl[3]  = '{6'b100001, 6'b000000, 1'b0, 2, 7, outs_t'{reg_write:1'b1, mem_to_reg:2'b01, load:2'b01, extended:1'b1, default:'0}, 0};
        tbl[4]  = '{6'b100101, 6'b000000, 1'b0, 0, 5, outs_t'{reg_write:1'b1, mem_to_reg:2'b01, load:2'b01, default:'0}, 0};
        tbl[5]  = '{6'b100000, 6'b000000, 1'b0, 0, 5, outs_t'{reg_write:1'b1, mem_to_reg:2'b01, load:2'b10, extended:1'b1, default:'0}, 0};
        tbl[6]  = '{6'b100100, 6'b000000, 1'b0, 1, 6, outs_t'{reg_write:1'b1, mem_to_reg:2'b01, load:2'b10, default:'0}, 0};
        tbl[7]  = '{6'b101011, 6'b000000, 1'b0, 0, 4, outs_t'{mem_write:1'b1, iord:1'b1, default:'0}, 0};
        tbl[8]  = '{6'b101001, 6'b000000, 1'b0, 0, 4, outs_t'{mem_write:1'b1, iord:1'b1, load:2'b01, default:'0}, 0};
        tbl[9]  = '{6'b101000, 6'b000000, 1'b0, 1, 5, outs_t'{mem_write:1'b1, iord:1'b1, load:2'b10, default:'0}, 0};
        tbl[10] = '{6'b001000, 6'b000000, 1'b0, 0, 4, outs_t'{reg_write:1'b1, default:'0}, 0};
        tbl[11] = '{6'b001111, 6'b000000, 1'b0, 0, 4, outs_t'{reg_write:1'b1, lui_control:1'b1, default:'0}, 0};
        tbl[12] = '{6'b000100, 6'b000000, 1'b1, 0, 3, outs_t'{pc_write:1'b1, alu_src_a:1'b1, alu_op:2'b01, pc_source:2'b01, default:'0}, 0};
        tbl[13] = '{6'b000100, 6'b000000, 1'b0, 0, 3, outs_t'{alu_src_a:1'b1, alu_op:2'b01, pc_source:2'b01, default:'0}, 0};
        tbl[14] = '{6'b000010, 6'b000000, 1'b0, 0, 3, outs_t'{pc_write:1'b1, pc_source:2'b10, default:'0}, 0};
        tbl[15] = '{6'b000011, 6'b000000, 1'b0, 0, 3, outs_t'{pc_write:1'b1, pc_source:2'b10, reg_write:1'b1, reg_dst:2'b10, mem_to_reg:2'b10, default:'0}, 0};
        tbl[16] = '{6'b111111, 6'b000000, 1'b0, 0, 2, outs_t'{alu_src_b:2'b11, illegal:1'b1, default:'0}, 1};
        fetch_wait = outs_t'{mem_read:1'b1, alu_src_b:2'b01, default:'0};

        rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
        #2;
        check_outs("reset_outputs", snap(), '0);
`ifdef MC_PERF_CNT_EN
        check_int("reset_inst_count", int'(inst_count), 0);
`endif
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("idle_after_reset", snap(), '0);
        @(posedge clk); #1;
        check_outs("fetch_after_idle", snap(), fetch_wait);

        foreach (tbl[i]) begin
            sb_q.push_back('{i, tbl[i].cycles, tbl[i].fin, tbl[i].ill});
            run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].dwait, cyc, last, ill_cnt, both_cnt, tmo);
            e = sb_q.pop_front();
            if (tmo) begin
                checks++; failures++;
                $display("FAIL timeout vec%0d: no return to fetch within 30 cycles", e.idx);
            end else begin
                check_int($sformatf("cycles vec%0d", e.idx), cyc, e.cycles);
                check_outs($sformatf("final_outs vec%0d", e.idx), last, e.fin);
                check_int($sformatf("illegal_pulses vec%0d", e.idx), ill_cnt, e.ill);
                check_int($sformatf("rd_wr_overlap vec%0d", e.idx), both_cnt, 0);
            end
        end

        // Reset asserted while a load is stalled in its data access.
        opcode = 6'b100011; funct = '0; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_outs("memrd_stalled", snap(), outs_t'{mem_read:1'b1, iord:1'b1, default:'0});
        rst_n = 1'b0;
        #1;
        check_outs("reset_mid_memrd", snap(), '0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("idle_after_mid_reset", snap(), '0);
        @(posedge clk); #1;
        check_outs("fetch_after_mid_reset", snap(), fetch_wait);

`ifdef MC_PERF_CNT_EN
        begin
            int ic;
            ic = int'(inst_count);
            run_instr(6'b111111, 6'b000000, 1'b0, 0, cyc, last, ill_cnt, both_cnt, tmo);
            check_int("inst_count_illegal", int'(inst_count), ic + 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
